psx_pad_poller: RTL and testbench

Self-contained PlayStation/DualShock pad transaction sequencer clocked from the pixel clock. Every poll period it asserts SEL, shifts a fixed command frame out on TXD, samples the pad's reply on RXD, validates it and publishes an NES-style button byte. It sits between the pad pins and the video/game logic. It replaces the divided-clock controller path with a single-clock-domain design.

---
 rtl/psx_pad_poller.sv | 273 +++++++++++++++++++++++++++
 tb/tb_psx_pad_poller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/psx_pad_poller.sv
// psx_pad_poller: single-clock PlayStation pad poller. Every poll period it
// lowers psSEL, shifts the 0x01,0x42,0x00.. command frame out on TXD (LSB
// first), samples the reply on RXD, checks the 0x5A marker and publishes an
// NES-style button byte with a one-cycle valid strobe.
// Optional feature macro: PSX_ANALOG_EN (9-byte analog frame, ID 0x73, axes).
module psx_pad_poller #(
  parameter int PIXEL_CLOCK = 25_200_000,
  parameter int SCLK_HZ     = 250_000,
  parameter int POLL_HZ     = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        joyi,
  output logic [2:0]  joy,
  output logic [7:0]  btn,
  output logic        valid,
  output logic        err,
  output logic [31:0] axes
);
  localparam int H = PIXEL_CLOCK / SCLK_HZ / 2;
  localparam int P = PIXEL_CLOCK / POLL_HZ;
`ifdef PSX_ANALOG_EN
  localparam int N = 9;
`else
  localparam int N = 5;
`endif
  localparam int CW = $clog2(4 * H) + 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [CW-1:0] C_H1  = CW'(H - 1);
  localparam logic [CW-1:0] C_2H1 = CW'(2 * H - 1);
  localparam logic [CW-1:0] C_4H1 = CW'(4 * H - 1);
  localparam logic [PW-1:0] C_P1  = PW'(P - 1);
  localparam logic [3:0]    C_N1  = 4'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_GAP   = 3'd4,
    S_HOLD  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Command byte sent in frame position idx.
  function automatic logic [7:0] f_cmd(input logic [3:0] idx);
    case (idx)
      4'd0:    f_cmd = 8'h01;
      4'd1:    f_cmd = 8'h42;
      default: f_cmd = 8'h00;
    endcase
  endfunction

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [3:0]      r_byte, w_byte_nxt;
  logic            r_txd, w_txd_nxt;
  logic [7:0]      w_cmd_nxt;
  logic            w_sample, w_done, w_start, w_tick, w_ok;
  logic            w_sel_nxt, w_sclk_nxt;
  logic [PW-1:0]   r_poll;
  logic            r_pend;
  logic [2:0]      r_joy;
  logic [6:0]      r_shift;
  logic [7:0]      w_rx_byte;
  logic [7:0]      r_b2;
  logic [7:0]      r_cap_btn;
  logic [7:0]      r_btn;
  logic            r_valid, r_err;
`ifdef PSX_ANALOG_EN
  logic [7:0]      r_b1;
  logic [31:0]     r_cap_axes;
  logic [31:0]     r_axes;
`endif

  assign w_tick    = (r_poll == C_P1);
  // A poll tick that lands while a frame is still running is remembered and
  // served as soon as the FSM is back in IDLE; frames never overlap.
  assign w_start   = (r_state == S_IDLE) && (w_tick || r_pend);
  assign w_rx_byte = {joyi, r_shift};
`ifdef PSX_ANALOG_EN
  assign w_ok      = (r_b2 == 8'h5A) && (r_b1 == 8'h73);
`else
  assign w_ok      = (r_b2 == 8'h5A);
`endif
  assign w_sel_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
  assign w_sclk_nxt = (w_state_nxt != S_LOW);

  // Free-running poll period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_poll <= {PW{1'b0}};
    else if (w_tick) r_poll <= {PW{1'b0}};
    else r_poll <= r_poll + PW'(1);
  end

  // Deferred-poll flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= 1'b0;
    else if (w_start) r_pend <= 1'b0;
    else if (w_tick) r_pend <= 1'b1;
    else r_pend <= r_pend;
  end

  // Next-state, timer, bit/byte index and TXD selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_sample    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = {CW{1'b0}};
        if (w_start) begin
          w_state_nxt = S_SETUP;
          w_bit_nxt   = 3'd0;
          w_byte_nxt  = 4'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (r_cnt == C_2H1) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = S_SETUP;
        end
      end
      S_LOW: begin
        if (r_cnt == C_H1) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = S_LOW;
        end
      end
      S_HIGH: begin
        w_sample = (r_cnt == {CW{1'b0}});
        if (r_cnt == C_H1) begin
          w_cnt_nxt = {CW{1'b0}};
          if (r_bit == 3'd7) begin
            w_bit_nxt   = 3'd0;
            w_state_nxt = (r_byte == C_N1) ? S_HOLD : S_GAP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_state_nxt = S_LOW;
          end
        end else begin
          w_state_nxt = S_HIGH;
        end
      end
      S_GAP: begin
        if (r_cnt == C_4H1) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = {CW{1'b0}};
          w_byte_nxt  = r_byte + 4'd1;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_HOLD: begin
        if (r_cnt == C_2H1) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
    w_cmd_nxt = f_cmd(w_byte_nxt);
    // TXD only moves when psCLK falls, giving a full half-bit of setup.
    if ((w_state_nxt == S_LOW) && (r_state != S_LOW)) w_txd_nxt = w_cmd_nxt[w_bit_nxt];
    else w_txd_nxt = r_txd;
  end

  // FSM state register and registered pad pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_bit   <= 3'd0;
      r_byte  <= 4'd0;
      r_txd   <= 1'b1;
      r_joy   <= 3'b111;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_txd   <= w_txd_nxt;
      r_joy   <= {w_txd_nxt, w_sel_nxt, w_sclk_nxt};
    end
  end

  // Reply shift register and capture of the bytes that matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= 7'd0;
      r_b2       <= 8'h00;
      r_cap_btn  <= 8'h00;
`ifdef PSX_ANALOG_EN
      r_b1       <= 8'h00;
      r_cap_axes <= 32'h0;
`endif
    end else if (w_sample) begin
      r_shift <= w_rx_byte[7:1];
      if (r_bit == 3'd7) begin
        case (r_byte)
`ifdef PSX_ANALOG_EN
          4'd1: r_b1 <= w_rx_byte;
          4'd5: r_cap_axes[7:0]   <= w_rx_byte;
          4'd6: r_cap_axes[15:8]  <= w_rx_byte;
          4'd7: r_cap_axes[23:16] <= w_rx_byte;
          4'd8: r_cap_axes[31:24] <= w_rx_byte;
`endif
          4'd2: r_b2 <= w_rx_byte;
          4'd3: r_cap_btn[7:2] <= ~{w_rx_byte[5], w_rx_byte[7], w_rx_byte[6],
                                    w_rx_byte[4], w_rx_byte[3], w_rx_byte[0]};
          4'd4: r_cap_btn[1:0] <= ~{w_rx_byte[6], w_rx_byte[5]};
          default: r_shift <= w_rx_byte[7:1];
        endcase
      end
    end
  end

  // Validate the finished frame and publish buttons/axes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn   <= 8'h00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
`ifdef PSX_ANALOG_EN
      r_axes  <= 32'h0;
`endif
    end else if (w_done) begin
      if (w_ok) begin
        r_btn   <= r_cap_btn;
        r_valid <= 1'b1;
        r_err   <= 1'b0;
`ifdef PSX_ANALOG_EN
        r_axes  <= r_cap_axes;
`endif
      end else begin
        r_valid <= 1'b0;
        r_err   <= 1'b1;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign joy   = r_joy;
  assign btn   = r_btn;
  assign valid = r_valid;
  assign err   = r_err;
`ifdef PSX_ANALOG_EN
  assign axes  = r_axes;
`else
  assign axes  = 32'h0;
`endif
endmodule

// File: tb/tb_psx_pad_poller.sv
// tb_psx_pad_poller: table-driven frame vectors against a behavioural pad,
// plus reset/idle and mid-frame reset sequences. Scaled clocks: H=3, P=4000.
module tb_psx_pad_poller;
  localparam int H = 3;
  localparam int P = 4000;
`ifdef PSX_ANALOG_EN
  localparam int N = 9;
  localparam bit AN = 1'b1;
`else
  localparam int N = 5;
  localparam bit AN = 1'b0;
`endif
  localparam int FLEN = 2*H + N*16*H + (N-1)*4*H + 2*H;
  localparam logic [7:0]  ID_OK  = AN ? 8'h73 : 8'h41;
  localparam logic [31:0] AX_EXP = AN ? 32'hF010_8080 : 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        joyi;
  logic [2:0]  joy;
  logic [7:0]  btn;
  logic        valid, err;
  logic [31:0] axes;

  psx_pad_poller #(.PIXEL_CLOCK(25_200_000), .SCLK_HZ(4_200_000), .POLL_HZ(6_300)) dut (
    .clk(clk), .rst(rst), .joyi(joyi), .joy(joy),
    .btn(btn), .valid(valid), .err(err), .axes(axes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       disc;
    logic [7:0] id, b2, b3, b4;
    logic [7:0] exp_btn;
    logic       exp_err;
  } vec_t;
  vec_t vecs [0:7];

  int n_vec = 0, n_bad = 0;
  int cyc = 0, falls = 0, frames_done = 0, vld_cnt = 0;
  int fall_cyc = 0, rise_cyc = 0, vld_cyc = 0;
  int k = 0;
  logic prev_sel = 1'b1, prev_sclk = 1'b1;
  logic [71:0] tx_cap = 72'h0;
  logic [7:0]  rep [0:8];
  logic        pad_disc = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_rep(input vec_t v);
    rep[0] = 8'hFF; rep[1] = v.id; rep[2] = v.b2; rep[3] = v.b3; rep[4] = v.b4;
    rep[5] = 8'h80; rep[6] = 8'h80; rep[7] = 8'h10; rep[8] = 8'hF0;
    pad_disc = v.disc;
  endtask

  // Wait (bounded) until psSEL returns high, then let the result settle.
  task automatic wait_frame(input string name);
    int fd0;
    fd0 = frames_done;
    for (int t = 0; t < 2*P && frames_done == fd0; t++) tick();
    check({name, "_timeout"}, 72'(frames_done != fd0), 72'(1));
    repeat (3) tick();
  endtask

  // Pad model and bus monitor: shifts the reply on each psCLK fall and
  // records TXD, psSEL edges and valid strobes (cycle-stamped).
  initial begin : pad
    joyi = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_sel && !joy[1]) begin
        tx_cap = 72'h0; fall_cyc = cyc; falls++;
      end
      if (!prev_sel && joy[1]) begin
        rise_cyc = cyc; frames_done++;
      end
      if (valid === 1'b1) begin
        vld_cnt++; vld_cyc = cyc;
      end
      if (joy[1]) begin
        k = 0; joyi = 1'b1;
      end else if (prev_sclk && !joy[0]) begin
        if (k < 72) tx_cap[k] = joy[2];
        if (pad_disc || k >= 72) joyi = 1'b1;
        else joyi = rep[k/8][k%8];
        k++;
      end
      prev_sel  = joy[1];
      prev_sclk = joy[0];
    end
  end

  initial begin : main
    int rel_cyc, v0, bad, prev_fall, f0;
    logic [31:0] exp_ax;
    vecs[0] = '{1'b0, ID_OK, 8'h5A, 8'hEF, 8'hBF, 8'h12, 1'b0};
    vecs[1] = '{1'b0, ID_OK, 8'h00, 8'h00, 8'h00, 8'h12, 1'b1};
    vecs[2] = '{1'b0, ID_OK, 8'h5A, 8'h7E, 8'h9F, 8'h47, 1'b0};
    vecs[3] = '{1'b1, ID_OK, 8'h5A, 8'h00, 8'h00, 8'h47, 1'b1};
    vecs[4] = '{1'b1, ID_OK, 8'h5A, 8'h00, 8'h00, 8'h47, 1'b1};
    vecs[5] = '{1'b0, ID_OK, 8'h5B, 8'h00, 8'h00, 8'h47, 1'b1};
    vecs[6] = '{1'b0, 8'h41, 8'h5A, 8'h7E, 8'h9F, 8'h47, AN};
    vecs[7] = '{1'b0, ID_OK, 8'h5A, 8'hD7, 8'hFF, 8'h88, 1'b0};
    exp_ax = 32'h0;

    repeat (3) tick();
    check("rst_joy", 72'(joy), 72'(3'b111));
    check("rst_btn", 72'(btn), 72'(0));
    check("rst_valid_err", 72'({valid, err}), 72'(0));
    check("rst_axes", 72'(axes), 72'(0));

    load_rep(vecs[0]);
    rst = 1'b0;
    rel_cyc = cyc;
    bad = 0;
    for (int i = 1; i < P; i++) begin
      tick();
      if (joy !== 3'b111 || btn !== 8'h00) bad++;
    end
    check("idle_joy_btn", 72'(bad), 72'(0));
    tick();
    check("sel_fall_at_P", 72'(joy[1]), 72'(0));
    check("first_fall_cycle", 72'(fall_cyc - rel_cyc), 72'(P));
    prev_fall = fall_cyc;

    for (int i = 0; i < 8; i++) begin
      if (i > 0) load_rep(vecs[i]);
      v0 = vld_cnt;
      wait_frame($sformatf("v%0d", i));
      if (i > 0) check($sformatf("v%0d_poll_period", i), 72'(fall_cyc - prev_fall), 72'(P));
      prev_fall = fall_cyc;
      check($sformatf("v%0d_frame_len", i), 72'(rise_cyc - fall_cyc), 72'(FLEN));
      check($sformatf("v%0d_txd", i), tx_cap, 72'h4201);
      check($sformatf("v%0d_valid_cnt", i), 72'(vld_cnt - v0), 72'(!vecs[i].exp_err));
      if (!vecs[i].exp_err) begin
        check($sformatf("v%0d_valid_delay", i), 72'(vld_cyc - rise_cyc), 72'(1));
        exp_ax = AX_EXP;
      end
      check($sformatf("v%0d_btn", i), 72'(btn), 72'(vecs[i].exp_btn));
      check($sformatf("v%0d_err", i), 72'(err), 72'(vecs[i].exp_err));
      check($sformatf("v%0d_axes", i), 72'(axes), 72'(exp_ax));
    end

    // Mid-frame reset during byte 3.
    f0 = falls;
    for (int t = 0; t < 2*P && falls == f0; t++) tick();
    check("mr_fall_timeout", 72'(falls != f0), 72'(1));
    repeat (2*H + 3*16*H + 3*4*H + 4) tick();
    v0 = vld_cnt;
    rst = 1'b1;
    #1;
    check("mr_joy_async", 72'(joy), 72'(3'b111));
    check("mr_btn_cleared", 72'(btn), 72'(0));
    repeat (3) tick();
    rst = 1'b0;
    rel_cyc = cyc;
    bad = 0;
    for (int i = 1; i < P; i++) begin
      tick();
      if (joy !== 3'b111 || valid !== 1'b0) bad++;
    end
    check("mr_idle_no_valid", 72'(bad), 72'(0));
    tick();
    check("mr_fall_cycle", 72'(fall_cyc - rel_cyc), 72'(P));
    check("mr_no_valid_cnt", 72'(vld_cnt - v0), 72'(0));
    wait_frame("mr_next");
    check("mr_next_len", 72'(rise_cyc - fall_cyc), 72'(FLEN));
    check("mr_next_btn", 72'(btn), 72'(8'h88));
    check("mr_next_err", 72'(err), 72'(0));
    check("mr_next_axes", 72'(axes), 72'(AX_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
